sram_port_arbiter: RTL and testbench
====================================

// Module: sram_port_arbiter
// PURPOSE
//  Shares one single-port synchronous SRAM (1-cycle read latency) between the fetch requester (inst_*) and the
//  load/store requester (data_*). Grants at most one access per cycle using a req/addr_ok/data_ok handshake.
//  Routes each response back to its owner one cycle later. Data side has priority; a starvation counter
//  guarantees forward progress for fetch. Sits between the IF/MEM stages and the unified SRAM.
// PARAMETERS
//  ADDR_W        32  address width, both requesters and SRAM
//  DATA_W        32  data width; write strobe width is DATA_W/8
//  STARVE_LIMIT  4   consecutive denied inst cycles before inst is forced to win (1..2**CNT_W-1)
//  CNT_W         3   width of the starvation counter
// PORTS
//  clk           in   1         clock
//  resetn        in   1         synchronous, active-low reset
//  inst_req      in   1         fetch read request (read only)
//  inst_addr     in   ADDR_W    fetch address
//  inst_addr_ok  out  1         fetch request granted this cycle
//  inst_data_ok  out  1         fetch read data valid on inst_rdata
//  inst_rdata    out  DATA_W    fetch read data
//  data_req      in   1         load/store request
//  data_wr       in   1         1 = write, 0 = read
//  data_wstrb    in   DATA_W/8  byte write enables (used when data_wr=1)
//  data_addr     in   ADDR_W    load/store address
//  data_wdata    in   DATA_W    store data
//  data_addr_ok  out  1         data request granted this cycle
//  data_data_ok  out  1         data access complete; read data valid on data_rdata
//  data_rdata    out  DATA_W    load data
//  sram_en       out  1         SRAM enable
//  sram_we       out  DATA_W/8  SRAM byte write enables
//  sram_addr     out  ADDR_W    SRAM address
//  sram_wdata    out  DATA_W    SRAM write data
//  sram_rdata    in   DATA_W    SRAM read data, valid cycle after sram_en
// BEHAVIOUR
//  - Grant (combinational, same cycle): gnt_d = resetn & data_req & ~force_i; gnt_i = resetn & inst_req & ~gnt_d.
//    force_i = inst_req & (starve_cnt == STARVE_LIMIT). Exactly one of gnt_d/gnt_i or neither is 1.
//  - inst_addr_ok = gnt_i; data_addr_ok = gnt_d. A requester holds req/addr/wdata stable until addr_ok.
//  - SRAM drive: sram_en = gnt_d|gnt_i; sram_addr = gnt_d ? data_addr : inst_addr;
//    sram_we = (gnt_d & data_wr) ? data_wstrb : 0; sram_wdata = data_wdata. No grant -> en=0, we=0.
//  - Response: registers rsp_i <= gnt_i, rsp_d <= gnt_d each cycle; inst_data_ok = rsp_i, data_data_ok = rsp_d.
//    Latency exactly 1 cycle from addr_ok to data_ok for reads and writes. Fully pipelined: new grant every cycle.
//  - inst_rdata = data_rdata = sram_rdata (valid only while the matching data_ok=1; no buffering, the
//    requester must accept data_ok the cycle it is asserted).
//  - Starvation counter starve_cnt: reset 0. inst_req & ~gnt_i -> +1, saturating at STARVE_LIMIT;
//    gnt_i or ~inst_req -> 0. When forced, inst wins and data_req sees data_addr_ok=0 that cycle.
//  - Simultaneous req, counter below limit: data wins, inst retries next cycle (counter +1).
//  - Reset (resetn=0, any cycle incl. mid-access): rsp_i, rsp_d, starve_cnt -> 0; addr_ok, sram_en, sram_we all 0
//    during reset; any in-flight response is dropped (no data_ok after reset).
//  - Read-after-write same address back-to-back: write in cycle N, read granted N+1 returns written data (SRAM order).
// TESTING
//  - inst_req only, addr 0x1c000000 -> inst_addr_ok same cycle, inst_data_ok next cycle, rdata = mem[0x1c000000].
//  - data_req read + inst_req same cycle -> data_addr_ok=1, inst_addr_ok=0; next cycle data_data_ok=1, inst granted.
//  - data_req held high 5 cycles with inst_req high -> data wins cycles 0-3, inst forced on cycle 4, counter -> 0.
//  - data write wstrb=4'b0011 wdata=0xAABBCCDD to 0x100 then read 0x100 (old 0x11223344) -> rdata 0x1122CCDD.
//  - resetn low the cycle after an inst grant -> inst_data_ok stays 0; all outputs 0 while resetn=0.
//  - Alternating inst/data reqs every cycle for 100 cycles -> one grant/cycle, every addr_ok matched by one data_ok.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Arbitrates one single-port synchronous SRAM between fetch (inst_*) and load/store (data_*) requesters.
// Data side has priority; a starvation counter forces a fetch grant after STARVE_LIMIT denied cycles.
module sram_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                sram_en,
  output logic [DATA_W/8-1:0] sram_we,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata
);

  logic [CNT_W-1:0] starve_cnt;
  logic             force_i;
  logic             gnt_d;
  logic             gnt_i;
  logic             rsp_i;
  logic             rsp_d;

  always_comb begin
    force_i = inst_req & (starve_cnt == CNT_W'(STARVE_LIMIT));
    gnt_d   = resetn & data_req & ~force_i;
    gnt_i   = resetn & inst_req & ~gnt_d;
  end

  always_comb begin
    inst_addr_ok = gnt_i;
    data_addr_ok = gnt_d;
    sram_en      = gnt_d | gnt_i;
    sram_addr    = gnt_d ? data_addr : inst_addr;
    sram_we      = (gnt_d & data_wr) ? data_wstrb : '0;
    sram_wdata   = data_wdata;
  end

  // Responses are gated by resetn so a grant issued just before reset never surfaces as data_ok.
  always_comb begin
    inst_data_ok = rsp_i & resetn;
    data_data_ok = rsp_d & resetn;
    inst_rdata   = sram_rdata;
    data_rdata   = sram_rdata;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rsp_i      <= 1'b0;
      rsp_d      <= 1'b0;
      starve_cnt <= '0;
    end else begin
      rsp_i <= gnt_i;
      rsp_d <= gnt_d;
      if (inst_req && !gnt_i) begin
        if (starve_cnt != CNT_W'(STARVE_LIMIT))
          starve_cnt <= starve_cnt + 1'b1;
      end else begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed-vector bench for sram_port_arbiter: per-cycle grant checks plus a queue scoreboard
// that a separate monitor drains whenever a data_ok appears.
module tb_sram_port_arbiter;

  logic        clk;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  sram_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4), .CNT_W(3)
  ) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM environment model: 1-cycle read latency, byte-masked writes.
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hA5A5_0000;
  endfunction

  always @(posedge clk) begin
    if (sram_en) begin
      logic [31:0] w;
      w = mem_rd(sram_addr);
      sram_rdata <= w;
      for (int b = 0; b < 4; b++)
        if (sram_we[b]) w[b*8 +: 8] = sram_wdata[b*8 +: 8];
      if (sram_we != 4'b0) mem[sram_addr] = w;
    end
  end

  typedef struct {
    bit          rst;
    bit          ir;
    logic [31:0] ia;
    bit          dr;
    bit          dw;
    logic [3:0]  ds;
    logic [31:0] da;
    logic [31:0] dd;
    bit          egi;
    bit          egd;
    logic [31:0] erd;
  } vec_t;

  typedef struct {
    bit          chk;
    logic [31:0] val;
  } exp_t;

  exp_t q_i[$];
  exp_t q_d[$];
  int   errors   = 0;
  int   checks   = 0;
  int   n_grants = 0;
  int   n_ok     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input bit rst, input bit ir, input logic [31:0] ia,
                              input bit dr, input bit dw, input logic [3:0] ds,
                              input logic [31:0] da, input logic [31:0] dd,
                              input bit egi, input bit egd, input logic [31:0] erd);
    vec_t v;
    v.rst = rst; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.ds = ds;
    v.da = da; v.dd = dd; v.egi = egi; v.egd = egd; v.erd = erd;
    return v;
  endfunction

  // Inputs change just after posedge; grants are checked at negedge; expected responses queued.
  task automatic run_vec(input vec_t v, input bit push);
    logic [3:0] exp_we;
    @(posedge clk);
    #1;
    resetn     = ~v.rst;
    inst_req   = v.ir;
    inst_addr  = v.ia;
    data_req   = v.dr;
    data_wr    = v.dw;
    data_wstrb = v.ds;
    data_addr  = v.da;
    data_wdata = v.dd;
    @(negedge clk);
    exp_we = (v.egd && v.dw) ? v.ds : 4'b0;
    chk("inst_addr_ok", {31'b0, inst_addr_ok}, {31'b0, v.egi});
    chk("data_addr_ok", {31'b0, data_addr_ok}, {31'b0, v.egd});
    chk("sram_en", {31'b0, sram_en}, {31'b0, v.egi | v.egd});
    chk("sram_we", {28'b0, sram_we}, {28'b0, exp_we});
    if (v.egi || v.egd) chk("sram_addr", sram_addr, v.egd ? v.da : v.ia);
    if (v.egd && v.dw) chk("sram_wdata", sram_wdata, v.dd);
    if (v.rst) begin
      chk("inst_data_ok_rst", {31'b0, inst_data_ok}, 32'd0);
      chk("data_data_ok_rst", {31'b0, data_data_ok}, 32'd0);
    end
    if (push) begin
      if (v.egi) begin q_i.push_back('{1'b1, v.erd}); n_grants++; end
      if (v.egd) begin q_d.push_back('{~v.dw, v.erd}); n_grants++; end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (inst_data_ok) begin
        n_ok++;
        if (q_i.size() == 0) chk("inst_unexpected_data_ok", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = q_i.pop_front();
          if (e.chk) chk("inst_rdata", inst_rdata, e.val);
        end
      end
      if (data_data_ok) begin
        n_ok++;
        if (q_d.size() == 0) chk("data_unexpected_data_ok", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = q_d.pop_front();
          if (e.chk) chk("data_rdata", data_rdata, e.val);
        end
      end
    end
  end

  localparam logic [31:0] IA0 = 32'h1c00_0000;
  localparam logic [31:0] IA1 = 32'h1c00_0004;

  initial begin
    mem[IA0]          = 32'hDEAD_BEEF;
    mem[IA1]          = 32'h0123_4567;
    mem[32'h0000_0100] = 32'h1122_3344;
    mem[32'h0000_0200] = 32'h5566_7788;
    mem[32'h0000_0300] = 32'h0BAD_F00D;
    resetn = 1'b0; inst_req = 1'b0; inst_addr = '0; data_req = 1'b0; data_wr = 1'b0;
    data_wstrb = '0; data_addr = '0; data_wdata = '0;

    // Reset with both requests high: nothing granted, nothing returned.
    repeat (3) run_vec(mk(1, 1, IA0, 1, 1, 4'hF, 32'h100, 32'h0, 0, 0, 0), 0);

    run_vec(mk(0, 1, IA0, 0, 0, 4'h0, 32'h0,   32'h0, 1, 0, 32'hDEAD_BEEF), 1);
    run_vec(mk(0, 1, IA1, 1, 0, 4'h0, 32'h200, 32'h0, 0, 1, 32'h5566_7788), 1);
    run_vec(mk(0, 1, IA1, 0, 0, 4'h0, 32'h0,   32'h0, 1, 0, 32'h0123_4567), 1);
    // Data held with inst waiting: four data wins, then the fetch is forced.
    for (int k = 0; k < 4; k++)
      run_vec(mk(0, 1, IA0, 1, 0, 4'h0, 32'h300, 32'h0, 0, 1, 32'h0BAD_F00D), 1);
    run_vec(mk(0, 1, IA0, 1, 0, 4'h0, 32'h300, 32'h0, 1, 0, 32'hDEAD_BEEF), 1);
    // Counter cleared by the forced grant, so data wins again immediately.
    run_vec(mk(0, 1, IA0, 1, 0, 4'h0, 32'h300, 32'h0, 0, 1, 32'h0BAD_F00D), 1);
    run_vec(mk(0, 1, IA0, 0, 0, 4'h0, 32'h0,   32'h0, 1, 0, 32'hDEAD_BEEF), 1);
    run_vec(mk(0, 0, IA0, 1, 1, 4'b0011, 32'h100, 32'hAABB_CCDD, 0, 1, 32'h0), 1);
    run_vec(mk(0, 0, IA0, 1, 0, 4'h0, 32'h100, 32'h0, 0, 1, 32'h1122_CCDD), 1);
    run_vec(mk(0, 0, IA0, 0, 0, 4'h0, 32'h0,   32'h0, 0, 0, 32'h0), 1);

    // Reset the cycle after a fetch grant: that response must never appear.
    run_vec(mk(0, 1, IA1, 0, 0, 4'h0, 32'h0,   32'h0, 1, 0, 32'h0), 0);
    run_vec(mk(1, 1, IA1, 1, 0, 4'h0, 32'h200, 32'h0, 0, 0, 32'h0), 0);
    run_vec(mk(1, 0, IA1, 0, 0, 4'h0, 32'h0,   32'h0, 0, 0, 32'h0), 0);
    run_vec(mk(0, 0, IA1, 0, 0, 4'h0, 32'h0,   32'h0, 0, 0, 32'h0), 1);

    for (int i = 0; i < 100; i++) begin
      if (i % 2 == 0)
        run_vec(mk(0, 1, IA0, 0, 0, 4'h0, 32'h0,   32'h0, 1, 0, 32'hDEAD_BEEF), 1);
      else
        run_vec(mk(0, 0, IA0, 1, 0, 4'h0, 32'h200, 32'h0, 0, 1, 32'h5566_7788), 1);
    end

    repeat (3) run_vec(mk(0, 0, IA0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0), 1);

    chk("inst_queue_drained", q_i.size(), 32'd0);
    chk("data_queue_drained", q_d.size(), 32'd0);
    chk("grants_vs_data_ok", n_ok, n_grants);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
